multi_key_start: RTL and testbench

- Parametrised, multi-channel push-button front end for the MNIST board demo.
- Each key path has a 2-flop synchroniser, a debouncer, press/release pulse generation and a retriggerable active-low LED hold timer.
- A shared start sequencer arbitrates presses and issues a single-cycle start pulse, tagged with the key index, a fixed delay after the press.
- Sits between board pins and the inference controller; it replaces the single-key start logic.

---
 rtl/multi_key_start_pkg.sv | 22 ++
 rtl/key_debounce.sv | 126 ++++++++++++
 rtl/multi_key_start.sv | 124 ++++++++++++
 tb/tb_multi_key_start.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_key_start_pkg.sv
// Shared types, defaults and helpers for the multi-key start front end.
// Optional long-press detection is enabled by MULTI_KEY_START_LONG_PRESS_EN.
package multi_key_start_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    FIRE  = 2'd2
  } start_state_e;

  localparam int unsigned DEF_N_KEYS          = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_LED_CYCLES      = 50000000;
  localparam int unsigned DEF_START_DELAY     = 1000;
  localparam int unsigned DEF_LONG_CYCLES     = 100000000;

  // Bits needed to index/hold 'value' distinct states, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 1) ? 1 : int'($clog2(value));
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchroniser, debouncer, press/release pulses, LED hold.
// Adds a long-press pulse when MULTI_KEY_START_LONG_PRESS_EN is defined.
module key_debounce
  import multi_key_start_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LED_CYCLES      = DEF_LED_CYCLES,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
`ifdef MULTI_KEY_START_LONG_PRESS_EN
  , parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
`ifdef MULTI_KEY_START_LONG_PRESS_EN
  output logic key_long,
`endif
  output logic dout_led
);

  localparam int unsigned DB_W  = clog2_min1(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LED_W = clog2_min1(LED_CYCLES + 1);

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             level_q, level_d, press_q, press_d, release_q, release_d;
  logic [LED_W-1:0] led_cnt_q, led_cnt_d;
  logic             led_q, led_d;

  // Synchroniser stages hold the normalised level, 1 = pressed.
  always_comb begin
    sync1_d = KEY_ACTIVE_LOW ? ~key_in : key_in;
    sync2_d = sync1_q;
  end

  always_comb begin
    db_cnt_d  = db_cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt_d  = '0;
      level_d   = ~level_q;
      press_d   = ~level_q;
      release_d = level_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Retriggerable hold: a new press reloads the full on-time.
  always_comb begin
    led_cnt_d = led_cnt_q;
    if (press_q) begin
      led_cnt_d = LED_W'(LED_CYCLES);
    end else if (led_cnt_q != '0) begin
      led_cnt_d = led_cnt_q - LED_W'(1);
    end
    led_d = (led_cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      led_cnt_q <= '0;
      led_q     <= 1'b1;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      led_cnt_q <= led_cnt_d;
      led_q     <= led_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign dout_led    = led_q;

`ifdef MULTI_KEY_START_LONG_PRESS_EN
  localparam int unsigned LONG_W = clog2_min1(LONG_CYCLES + 1);

  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic              long_q, long_d;

  // Saturates at LONG_CYCLES so the pulse fires once per hold.
  always_comb begin
    long_cnt_d = long_cnt_q;
    long_d     = 1'b0;
    if (!level_q) begin
      long_cnt_d = '0;
    end else if (long_cnt_q != LONG_W'(LONG_CYCLES)) begin
      long_cnt_d = long_cnt_q + LONG_W'(1);
      long_d     = (long_cnt_d == LONG_W'(LONG_CYCLES));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      long_q     <= long_d;
    end
  end

  assign key_long = long_q;
`endif

endmodule

// File: rtl/multi_key_start.sv
// Multi-key push-button front end with a shared, delayed start sequencer.
// Optional long-press output is enabled by MULTI_KEY_START_LONG_PRESS_EN.
module multi_key_start
  import multi_key_start_pkg::*;
#(
  parameter int unsigned N_KEYS          = DEF_N_KEYS,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LED_CYCLES      = DEF_LED_CYCLES,
  parameter int unsigned START_DELAY     = DEF_START_DELAY,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
`ifdef MULTI_KEY_START_LONG_PRESS_EN
  , parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES
`endif
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_KEYS-1:0]               key_in,
  input  logic                            start_ready,
  output logic [N_KEYS-1:0]               key_level,
  output logic [N_KEYS-1:0]               key_press,
  output logic [N_KEYS-1:0]               key_release,
`ifdef MULTI_KEY_START_LONG_PRESS_EN
  output logic [N_KEYS-1:0]               key_long,
`endif
  output logic [N_KEYS-1:0]               dout_led,
  output logic                            dout_start,
  output logic [clog2_min1(N_KEYS)-1:0]   start_id,
  output logic                            start_busy
);

  localparam int unsigned ID_W  = clog2_min1(N_KEYS);
  localparam int unsigned DLY_W = clog2_min1(START_DELAY + 1);

  for (genvar g = 0; g < int'(N_KEYS); g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LED_CYCLES      (LED_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
`ifdef MULTI_KEY_START_LONG_PRESS_EN
      , .LONG_CYCLES   (LONG_CYCLES)
`endif
    ) u_key (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in[g]),
      .key_level   (key_level[g]),
      .key_press   (key_press[g]),
      .key_release (key_release[g]),
`ifdef MULTI_KEY_START_LONG_PRESS_EN
      .key_long    (key_long[g]),
`endif
      .dout_led    (dout_led[g])
    );
  end

  logic            any_press;
  logic [ID_W-1:0] win_id;

  // Lowest pressed index wins.
  always_comb begin
    any_press = |key_press;
    win_id    = '0;
    for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
      if (key_press[i]) win_id = ID_W'(i);
    end
  end

  start_state_e     state_q, state_d;
  logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
  logic [ID_W-1:0]  id_next_q, id_next_d, start_id_q, start_id_d;
  logic             start_q, start_d, busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    dly_cnt_d  = dly_cnt_q;
    id_next_d  = id_next_q;
    start_id_d = start_id_q;
    start_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ready && any_press) begin
          id_next_d = win_id;
          dly_cnt_d = '0;
          state_d   = DELAY;
        end
      end
      DELAY: begin
        if (dly_cnt_q == DLY_W'(START_DELAY)) begin
          state_d    = FIRE;
          start_d    = 1'b1;
          start_id_d = id_next_q;
        end else begin
          dly_cnt_d = dly_cnt_q + DLY_W'(1);
        end
      end
      FIRE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DELAY) || (state_d == FIRE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dly_cnt_q  <= '0;
      id_next_q  <= '0;
      start_id_q <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_cnt_q  <= dly_cnt_d;
      id_next_q  <= id_next_d;
      start_id_q <= start_id_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
    end
  end

  assign dout_start = start_q;
  assign start_id   = start_id_q;
  assign start_busy = busy_q;

endmodule

// File: tb/tb_multi_key_start.sv
// Bench for multi_key_start: directed vector table, timed corner sequences, random vs model.
// Also exercises key_long when MULTI_KEY_START_LONG_PRESS_EN is defined.
module tb_multi_key_start;

  localparam int NK   = 4;
  localparam int DEB  = 8;
  localparam int LEDC = 20;
  localparam int SD   = 5;
  localparam int HL   = DEB + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_in;
  logic          start_ready;
  logic [NK-1:0] key_level, key_press, key_release, dout_led;
  logic          dout_start, start_busy;
  logic [1:0]    start_id;
`ifdef MULTI_KEY_START_LONG_PRESS_EN
  logic [NK-1:0] key_long;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_key_start #(
    .N_KEYS          (NK),
    .DEBOUNCE_CYCLES (DEB),
    .LED_CYCLES      (LEDC),
    .START_DELAY     (SD),
    .KEY_ACTIVE_LOW  (1'b1)
`ifdef MULTI_KEY_START_LONG_PRESS_EN
    , .LONG_CYCLES   (30)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .start_ready (start_ready),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
`ifdef MULTI_KEY_START_LONG_PRESS_EN
    .key_long    (key_long),
`endif
    .dout_led    (dout_led),
    .dout_start  (dout_start),
    .start_id    (start_id),
    .start_busy  (start_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset(input bit chk);
    rst_n = 1'b0;
    key_in = '1;
    start_ready = 1'b1;
    @(negedge clk);
    if (chk) begin
      check("rst_level",   32'(key_level),   32'd0);
      check("rst_press",   32'(key_press),   32'd0);
      check("rst_release", 32'(key_release), 32'd0);
      check("rst_led",     32'(dout_led),    32'hF);
      check("rst_start",   32'(dout_start),  32'd0);
      check("rst_id",      32'(start_id),    32'd0);
      check("rst_busy",    32'(start_busy),  32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  bit         m_hist [NK][HL];
  logic [NK-1:0] m_level, m_press, m_release, m_led;
  int         m_last_press [NK];
  int         m_edge, m_acc_edge, m_fire_edge;
  logic       m_start, m_busy;
  logic [1:0] m_id, m_id_next;

  function automatic logic [1:0] lowest(input logic [NK-1:0] v);
    for (int i = 0; i < NK; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_level = '0; m_press = '0; m_release = '0; m_led = '1;
    m_start = 1'b0; m_busy = 1'b0; m_id = '0; m_id_next = '0;
    m_acc_edge = -1000; m_fire_edge = -1000;
    for (int k = 0; k < NK; k++) begin
      m_last_press[k] = -1;
      for (int j = 0; j < HL; j++) m_hist[k][j] = 1'b0;
    end
  endtask

  // Computes the state after the coming clock edge.
  task automatic model_step(input logic rst, input logic [NK-1:0] pressed, input logic ready);
    bit flip;
    m_edge++;
    if (!rst) begin
      model_reset();
      return;
    end
    // A press seen after edge p is taken at p+1 if idle; the start fires START_DELAY+1 later.
    if (ready && (m_press != '0) && (m_edge >= m_fire_edge + 2)) begin
      m_acc_edge  = m_edge;
      m_fire_edge = m_edge + SD + 1;
      m_id_next   = lowest(m_press);
    end
    m_start = (m_edge == m_fire_edge);
    if (m_start) m_id = m_id_next;
    m_busy = (m_edge >= m_acc_edge) && (m_edge <= m_fire_edge);
    for (int k = 0; k < NK; k++) begin
      for (int j = HL - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
      m_hist[k][0] = pressed[k];
      m_led[k] = !((m_last_press[k] >= 0) && (m_edge >= m_last_press[k] + 1) &&
                   (m_edge <= m_last_press[k] + LEDC));
      // Level flips once DEB consecutive synchronised samples disagree with it.
      flip = 1'b1;
      for (int j = 2; j < HL; j++) if (m_hist[k][j] == m_level[k]) flip = 1'b0;
      m_press[k]   = flip && !m_level[k];
      m_release[k] = flip && m_level[k];
      if (flip) m_level[k] = ~m_level[k];
      if (m_press[k]) m_last_press[k] = m_edge;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [NK-1:0] keys;
    int            hold;
    logic          ready;
    logic [NK-1:0] exp_press;
    int            exp_starts;
    logic [1:0]    exp_id;
    logic [NK-1:0] exp_lit;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int            press_c, led_first, led_last, start_c, busy_n, starts;
    logic [1:0]    sid;
    logic [NK-1:0] seen_press, seen_lit;
    int            dur [NK];
    int            rst_hold;

    vecs[0] = '{keys:4'b0100, hold:40, ready:1'b1, exp_press:4'b0100, exp_starts:1, exp_id:2'd2, exp_lit:4'b0100};
    vecs[1] = '{keys:4'b0010, hold:7,  ready:1'b1, exp_press:4'b0000, exp_starts:0, exp_id:2'd0, exp_lit:4'b0000};
    vecs[2] = '{keys:4'b1001, hold:40, ready:1'b1, exp_press:4'b1001, exp_starts:1, exp_id:2'd0, exp_lit:4'b1001};
    vecs[3] = '{keys:4'b0010, hold:40, ready:1'b0, exp_press:4'b0010, exp_starts:0, exp_id:2'd0, exp_lit:4'b0010};
    vecs[4] = '{keys:4'b1000, hold:8,  ready:1'b1, exp_press:4'b1000, exp_starts:1, exp_id:2'd3, exp_lit:4'b1000};
    vecs[5] = '{keys:4'b1110, hold:9,  ready:1'b1, exp_press:4'b1110, exp_starts:1, exp_id:2'd1, exp_lit:4'b1110};

    rst_n = 1'b0; key_in = '1; start_ready = 1'b1;
    apply_reset(1'b1);

    for (int v = 0; v < 6; v++) begin
      apply_reset(1'b0);
      key_in = ~vecs[v].keys;
      start_ready = vecs[v].ready;
      seen_press = '0; seen_lit = '0; starts = 0;
      for (int c = 1; c <= 80; c++) begin
        @(negedge clk);
        seen_press |= key_press;
        seen_lit   |= ~dout_led;
        if (dout_start) starts++;
        if (c == vecs[v].hold) key_in = '1;
      end
      check($sformatf("vec%0d_press", v),  32'(seen_press), 32'(vecs[v].exp_press));
      check($sformatf("vec%0d_starts", v), 32'(starts),     32'(vecs[v].exp_starts));
      check($sformatf("vec%0d_id", v),     32'(start_id),   32'(vecs[v].exp_id));
      check($sformatf("vec%0d_lit", v),    32'(seen_lit),   32'(vecs[v].exp_lit));
      check($sformatf("vec%0d_led_end", v), 32'(dout_led),  32'hF);
    end

    // Exact timing of a single held key.
    apply_reset(1'b0);
    key_in = 4'b1011;
    press_c = -1; led_first = -1; led_last = -1; start_c = -1; busy_n = 0; sid = '0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (key_press[2] && press_c < 0) press_c = c;
      if (!dout_led[2]) begin
        if (led_first < 0) led_first = c;
        led_last = c;
      end
      if (dout_start && start_c < 0) begin start_c = c; sid = start_id; end
      if (start_busy) busy_n++;
    end
    key_in = '1;
    check("t_press_cycle", 32'(press_c),   32'd10);
    check("t_led_first",   32'(led_first), 32'd11);
    check("t_led_last",    32'(led_last),  32'd30);
    check("t_start_cycle", 32'(start_c),   32'd17);
    check("t_start_id",    32'(sid),       32'd2);
    check("t_busy_cycles", 32'(busy_n),    32'd7);

    // Second key pressed while the sequencer is in DELAY.
    apply_reset(1'b0);
    key_in = 4'b1110;
    starts = 0; seen_press = '0; seen_lit = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      seen_press |= key_press;
      seen_lit   |= ~dout_led;
      if (dout_start) starts++;
      if (c == 3)  key_in = 4'b1100;
      if (c == 40) key_in = '1;
    end
    check("d_starts", 32'(starts),     32'd1);
    check("d_id",     32'(start_id),   32'd0);
    check("d_press",  32'(seen_press), 32'b0011);
    check("d_lit",    32'(seen_lit),   32'b0011);

    // Reset during DELAY cancels the pending start.
    apply_reset(1'b0);
    key_in = 4'b1110;
    starts = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (dout_start) starts++;
      if (c == 15) begin
        check("r_led_in_reset",  32'(dout_led),   32'hF);
        check("r_busy_in_reset", 32'(start_busy), 32'd0);
      end
      if (c == 14) begin rst_n = 1'b0; key_in = '1; end
      if (c == 17) rst_n = 1'b1;
    end
    check("r_starts",  32'(starts),   32'd0);
    check("r_led_end", 32'(dout_led), 32'hF);

`ifdef MULTI_KEY_START_LONG_PRESS_EN
    apply_reset(1'b0);
    key_in = 4'b1011;
    press_c = -1; start_c = -1; starts = 0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (key_press[2] && press_c < 0) press_c = c;
      if (key_long[2]) begin
        starts++;
        if (start_c < 0) start_c = c;
      end
    end
    key_in = '1;
    check("l_long_delay", 32'(start_c - press_c), 32'd30);
    check("l_long_count", 32'(starts),            32'd1);
`endif

    // Randomised traffic against the reference model.
    apply_reset(1'b0);
    model_reset();
    m_edge = 0;
    rst_hold = 0;
    for (int k = 0; k < NK; k++) dur[k] = $urandom_range(1, 24);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < NK; k++) begin
        if (dur[k] == 0) begin
          key_in[k] = ~key_in[k];
          dur[k] = $urandom_range(1, 24);
        end else begin
          dur[k]--;
        end
      end
      start_ready = ($urandom_range(0, 6) != 0);
      if (rst_hold > 0) begin
        rst_hold--;
        rst_n = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        rst_hold = $urandom_range(0, 2);
        rst_n = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      model_step(rst_n, ~key_in, start_ready);
      @(negedge clk);
      check("rnd_level",   32'(key_level),   32'(m_level));
      check("rnd_press",   32'(key_press),   32'(m_press));
      check("rnd_release", 32'(key_release), 32'(m_release));
      check("rnd_led",     32'(dout_led),    32'(m_led));
      check("rnd_start",   32'(dout_start),  32'(m_start));
      check("rnd_id",      32'(start_id),    32'(m_id));
      check("rnd_busy",    32'(start_busy),  32'(m_busy));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
